win_banner_object: RTL and testbench

- Upstream object stage for the "win" banner bitmap. Tracks the banner's animated top-left position and, for each scanned pixel, produces bitmap-relative offsets plus an inside-rectangle flag.
- Those outputs feed the 50x20 monochrome win bitmap stage.
- On a win event, the banner slides down from above the screen to centre, holds, blinks, then stays steady until restart.

---
 rtl/win_banner_object_pkg.sv | 28 ++
 rtl/win_banner_object_if.sv | 26 ++
 rtl/win_banner_object_rect_hit_test.sv | 56 +++++
 rtl/win_banner_object.sv | 130 +++++++++++++
 tb/tb_win_banner_object.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/win_banner_object_pkg.sv
// Shared types and constants for the win-banner object stage and its hit-test helper.
package win_banner_object_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [10:0]        coord_t;
    typedef logic signed [11:0] pos_t;
    typedef logic [7:0]         frame_cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        SLIDE,
        HOLD,
        BLINK,
        DONE
    } banner_state_e;

    // Screen coordinates are always non-negative, so zero-extend into the signed domain.
    function automatic pos_t to_pos(input coord_t c);
        return pos_t'({1'b0, c});
    endfunction

    function automatic logic blink_on(input frame_cnt_t cnt, input int half);
        return ((int'(cnt) / half) % 2) == 0;
    endfunction

endpackage

// File: rtl/win_banner_object_if.sv
// Pixel-scan inputs, event pulses and banner outputs bundled between scan driver and banner stage.
interface win_banner_object_if;
    import win_banner_object_pkg::*;

    coord_t pixelX;
    coord_t pixelY;
    logic   startOfFrame;
    logic   winEvent;
    logic   restartReq;
    coord_t offsetX;
    coord_t offsetY;
    logic   InsideRectangle;
    logic   bannerActive;
    logic   bannerDone;

    modport master (
        output pixelX, pixelY, startOfFrame, winEvent, restartReq,
        input  offsetX, offsetY, InsideRectangle, bannerActive, bannerDone
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, winEvent, restartReq,
        output offsetX, offsetY, InsideRectangle, bannerActive, bannerDone
    );

endinterface

// File: rtl/win_banner_object_rect_hit_test.sv
// Registered rectangle hit test: flags a pixel inside a WIDTH x HEIGHT box at a signed
// top-left and reports the pixel's offset into the box (zero when outside).
module rect_hit_test
    import win_banner_object_pkg::*;
#(
    parameter int WIDTH  = 50,
    parameter int HEIGHT = 20
) (
    input  logic   clk,
    input  logic   rst_n,
    input  coord_t pixel_x_i,
    input  coord_t pixel_y_i,
    input  pos_t   top_x_i,
    input  pos_t   top_y_i,
    input  logic   visible_i,
    output coord_t offset_x_o,
    output coord_t offset_y_o,
    output logic   inside_o
);

    pos_t   px, py, right_x, bottom_y, dx, dy;
    logic   inside_d, inside_q;
    coord_t offset_x_d, offset_x_q, offset_y_d, offset_y_q;

    assign px       = to_pos(pixel_x_i);
    assign py       = to_pos(pixel_y_i);
    assign right_x  = top_x_i + pos_t'(WIDTH);
    assign bottom_y = top_y_i + pos_t'(HEIGHT);
    assign dx       = px - top_x_i;
    assign dy       = py - top_y_i;

    // A negative top only clips rows: py is never negative, so dy stays within 0..HEIGHT-1.
    always_comb begin
        inside_d   = visible_i && (px >= top_x_i) && (px < right_x)
                                && (py >= top_y_i) && (py < bottom_y);
        offset_x_d = inside_d ? coord_t'(dx[10:0]) : '0;
        offset_y_d = inside_d ? coord_t'(dy[10:0]) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inside_q   <= 1'b0;
            offset_x_q <= '0;
            offset_y_q <= '0;
        end else begin
            inside_q   <= inside_d;
            offset_x_q <= offset_x_d;
            offset_y_q <= offset_y_d;
        end
    end

    assign inside_o   = inside_q;
    assign offset_x_o = offset_x_q;
    assign offset_y_o = offset_y_q;

endmodule

// File: rtl/win_banner_object.sv
// Win banner object stage: slides the banner down to centre on a win, holds, blinks,
// then stays until restart; per-pixel hit/offset comes from rect_hit_test.
module win_banner_object
    import win_banner_object_pkg::*;
#(
    parameter int OBJECT_WIDTH_X = 50,
    parameter int OBJECT_HEIGHT_Y = 20,
    parameter int TARGET_X       = 295,
    parameter int TARGET_Y       = 230,
    parameter int START_Y        = -20,
    parameter int SPEED_Y        = 5,
    parameter int HOLD_FRAMES    = 60,
    parameter int BLINK_FRAMES   = 120,
    parameter int BLINK_HALF     = 8
) (
    input  logic clk,
    input  logic resetN,
    win_banner_object_if.slave bus
);

    localparam pos_t       TARGET_X_POS = pos_t'(TARGET_X);
    localparam pos_t       TARGET_Y_POS = pos_t'(TARGET_Y);
    localparam pos_t       START_Y_POS  = pos_t'(START_Y);
    localparam pos_t       SPEED_POS    = pos_t'(SPEED_Y);
    localparam frame_cnt_t HOLD_LAST    = frame_cnt_t'(HOLD_FRAMES - 1);
    localparam frame_cnt_t BLINK_LAST   = frame_cnt_t'(BLINK_FRAMES - 1);

    banner_state_e state_q, state_d;
    pos_t          top_y_q, top_y_d;
    frame_cnt_t    frame_cnt_q, frame_cnt_d;
    logic          visible;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            top_y_q     <= START_Y_POS;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            top_y_q     <= top_y_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Position and counter only advance on startOfFrame so a frame is never drawn half-moved.
    always_comb begin
        state_d     = state_q;
        top_y_d     = top_y_q;
        frame_cnt_d = frame_cnt_q;
        if (bus.restartReq) begin
            state_d     = IDLE;
            top_y_d     = START_Y_POS;
            frame_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.winEvent) begin
                        state_d     = SLIDE;
                        top_y_d     = START_Y_POS;
                        frame_cnt_d = '0;
                    end
                end
                SLIDE: begin
                    if (bus.startOfFrame) begin
                        if (top_y_q + SPEED_POS >= TARGET_Y_POS) begin
                            state_d     = HOLD;
                            top_y_d     = TARGET_Y_POS;
                            frame_cnt_d = '0;
                        end else begin
                            top_y_d = top_y_q + SPEED_POS;
                        end
                    end
                end
                HOLD: begin
                    if (bus.startOfFrame) begin
                        if (frame_cnt_q == HOLD_LAST) begin
                            state_d     = BLINK;
                            frame_cnt_d = '0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                BLINK: begin
                    if (bus.startOfFrame) begin
                        if (frame_cnt_q == BLINK_LAST) begin
                            state_d = DONE;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        visible = 1'b0;
        case (state_q)
            SLIDE, HOLD, DONE: visible = 1'b1;
            BLINK:             visible = blink_on(frame_cnt_q, BLINK_HALF);
            default:           visible = 1'b0;
        endcase
    end

    assign bus.bannerActive = (state_q != IDLE);
    assign bus.bannerDone   = (state_q == DONE);

    rect_hit_test #(
        .WIDTH  (OBJECT_WIDTH_X),
        .HEIGHT (OBJECT_HEIGHT_Y)
    ) u_hit (
        .clk        (clk),
        .rst_n      (resetN),
        .pixel_x_i  (bus.pixelX),
        .pixel_y_i  (bus.pixelY),
        .top_x_i    (TARGET_X_POS),
        .top_y_i    (top_y_q),
        .visible_i  (visible),
        .offset_x_o (bus.offsetX),
        .offset_y_o (bus.offsetY),
        .inside_o   (bus.InsideRectangle)
    );

endmodule

// File: tb/tb_win_banner_object.sv
// Scoreboard bench for win_banner_object: probes push expected outputs, a monitor pops and compares.
module tb_win_banner_object;
    import win_banner_object_pkg::*;

    typedef struct packed {
        logic        ins;
        logic [10:0] ox;
        logic [10:0] oy;
        logic        act;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic chk_en = 1'b0;
    logic chk_en_d = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t  exp_q[$];
    string name_q[$];

    win_banner_object_if bus();

    win_banner_object dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_one();
        exp_t  a, e;
        string nm;
        a = {bus.InsideRectangle, bus.offsetX, bus.offsetY, bus.bannerActive, bus.bannerDone};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output: got ins=%0b ox=%0d oy=%0d act=%0b done=%0b, nothing expected",
                     a.ins, a.ox, a.oy, a.act, a.done);
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got ins=%0b ox=%0d oy=%0d act=%0b done=%0b, want ins=%0b ox=%0d oy=%0d act=%0b done=%0b",
                         nm, a.ins, a.ox, a.oy, a.act, a.done, e.ins, e.ox, e.oy, e.act, e.done);
            end
        end
    endtask

    // Monitor: outputs for a probe are registered one edge after the probe is driven.
    always @(posedge clk) chk_en_d <= chk_en;
    always @(negedge clk) if (chk_en_d) check_one();

    task automatic push_exp(input string nm, input bit ins, input int ox, input int oy,
                            input bit act, input bit done);
        exp_t e;
        e.ins  = ins;
        e.ox   = 11'(ox);
        e.oy   = 11'(oy);
        e.act  = act;
        e.done = done;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic cyc(input bit sof, input bit win, input bit rr);
        @(negedge clk);
        chk_en           = 1'b0;
        bus.startOfFrame = sof;
        bus.winEvent     = win;
        bus.restartReq   = rr;
    endtask

    task automatic sofs(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic probe_px(input string nm, input int x, input int y, input bit ins,
                            input int ox, input int oy, input bit act, input bit done);
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        bus.winEvent     = 1'b0;
        bus.restartReq   = 1'b0;
        bus.pixelX       = 11'(x);
        bus.pixelY       = 11'(y);
        chk_en           = 1'b1;
        push_exp(nm, ins, ox, oy, act, done);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pixelX       = '0;
        bus.pixelY       = '0;
        bus.startOfFrame = 1'b0;
        bus.winEvent     = 1'b0;
        bus.restartReq   = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;

        // Idle frame scan: banner never shown.
        probe_px("reset_state", 0, 0, 0, 0, 0, 0, 0);
        for (int y = 0; y < 480; y += 16)
            for (int x = 0; x < 640; x += 16)
                probe_px("idle_scan", x, y, 0, 0, 0, 0, 0);
        probe_px("idle_centre", 295, 230, 0, 0, 0, 0, 0);
        cyc(1, 0, 0);
        probe_px("idle_after_sof", 300, 235, 0, 0, 0, 0, 0);

        // Slide: topY starts at -20, +5 per frame.
        cyc(0, 1, 0);
        probe_px("slide_start_offscreen", 295, 0, 0, 0, 0, 1, 0);
        sofs(1);
        probe_px("slide_f1_row0", 300, 0, 1, 5, 15, 1, 0);
        probe_px("slide_f1_lastrow", 300, 4, 1, 5, 19, 1, 0);
        probe_px("slide_f1_below", 300, 5, 0, 0, 0, 1, 0);
        sofs(48);
        probe_px("slide_f49_top", 295, 225, 1, 0, 0, 1, 0);
        probe_px("slide_f49_above", 295, 224, 0, 0, 0, 1, 0);
        sofs(1);

        // Hold at (295,230): edge pixels.
        probe_px("hold_topleft", 295, 230, 1, 0, 0, 1, 0);
        probe_px("hold_botright", 344, 249, 1, 49, 19, 1, 0);
        probe_px("hold_right_out", 345, 249, 0, 0, 0, 1, 0);
        probe_px("hold_left_out", 294, 230, 0, 0, 0, 1, 0);
        probe_px("hold_above_out", 295, 229, 0, 0, 0, 1, 0);
        probe_px("hold_below_out", 295, 250, 0, 0, 0, 1, 0);
        sofs(59);
        probe_px("hold_last_frame", 300, 240, 1, 5, 10, 1, 0);

        // Blink: frames 0-7 on, 8-15 off, 16 on again.
        sofs(1);
        probe_px("blink_f0_on", 300, 240, 1, 5, 10, 1, 0);
        sofs(7);
        probe_px("blink_f7_on", 300, 240, 1, 5, 10, 1, 0);
        sofs(1);
        probe_px("blink_f8_off", 300, 240, 0, 0, 0, 1, 0);
        sofs(7);
        probe_px("blink_f15_off", 300, 240, 0, 0, 0, 1, 0);
        sofs(1);
        probe_px("blink_f16_on", 300, 240, 1, 5, 10, 1, 0);
        sofs(103);
        probe_px("blink_f119", 300, 240, 1, 5, 10, 1, 0);
        sofs(1);
        probe_px("done_enter", 300, 240, 1, 5, 10, 1, 1);
        sofs(20);
        probe_px("done_steady", 344, 249, 1, 49, 19, 1, 1);

        // winEvent ignored in DONE; restart wins over a simultaneous winEvent.
        cyc(0, 1, 0);
        probe_px("done_win_ignored", 295, 230, 1, 0, 0, 1, 1);
        cyc(0, 1, 1);
        probe_px("restart_to_idle", 295, 230, 0, 0, 0, 0, 0);

        // Mid-slide asynchronous reset at topY = 100.
        cyc(0, 1, 0);
        sofs(24);
        probe_px("slide_y100", 300, 100, 1, 5, 0, 1, 0);
        @(negedge clk);
        chk_en = 1'b0;
        #2 resetN = 1'b0;
        #1;
        push_exp("async_reset_outputs", 0, 0, 0, 0, 0);
        check_one();
        @(negedge clk);
        #2 resetN = 1'b1;
        probe_px("post_reset_idle", 300, 100, 0, 0, 0, 0, 0);
        cyc(0, 1, 0);
        sofs(1);
        probe_px("reslide_f1_row0", 300, 0, 1, 5, 15, 1, 0);
        cyc(0, 0, 0);
        repeat (3) cyc(0, 0, 0);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
